// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions.
// Contents:
//   F3_*          load/store width codes carried in funct3
//   RES_*         WriteBack result-select encodings
//   isMisaligned  true when the access width does not fit the byte offset
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic result;
        result = 1'b0;
        case (funct3)
            F3_H, F3_HU: result = offset[0];
            F3_W:        result = (offset != 2'b00);
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// MEM -> WB bus bundle for the memory stage.
// M-side fields come from the EX/MEM register plus the WB hazard controls
// (StallW, FlushW); W-side fields are the MEM/WB register outputs.
// Modports: master drives M fields and hazard controls, slave is the stage.
// MisalignW exists only when MEM_MISALIGN_TRAP_EN is defined.
interface memory_stage_if;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ImmExtM;
    logic [9:0]  PCPlus4M;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic        MemWriteM;
    logic        RegWriteM;
    logic        StallW;
    logic        FlushW;

    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] ImmExtW;
    logic [9:0]  PCPlus4W;
    logic [4:0]  RdW;
    logic [1:0]  ResultSrcW;
    logic        RegWriteW;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    modport master (
        output ALUResultM, WriteDataM, ImmExtM, PCPlus4M, RdM, ResultSrcM,
               Funct3M, MemWriteM, RegWriteM, StallW, FlushW,
        input  ALUResultW, ReadDataW, ImmExtW, PCPlus4W, RdW, ResultSrcW,
`ifdef MEM_MISALIGN_TRAP_EN
               MisalignW,
`endif
               RegWriteW
    );

    modport slave (
        input  ALUResultM, WriteDataM, ImmExtM, PCPlus4M, RdM, ResultSrcM,
               Funct3M, MemWriteM, RegWriteM, StallW, FlushW,
        output ALUResultW, ReadDataW, ImmExtW, PCPlus4W, RdW, ResultSrcW,
`ifdef MEM_MISALIGN_TRAP_EN
               MisalignW,
`endif
               RegWriteW
    );

endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM with per-byte write enables.
// Ports:
//   clk        write clock (rising edge)
//   wordAddr   word index shared by read and write
//   byteEn     one enable per byte lane, lane 0 = bits 7:0
//   writeData  lane-aligned write data
//   readData   combinational read of the addressed word
// Contents are not reset.
module data_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] wordAddr,
    input  logic [3:0]        byteEn,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) begin
                mem[wordAddr][i*8 +: 8] <= writeData[i*8 +: 8];
            end
        end
    end

    assign readData = mem[wordAddr];

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: store lane generation, data memory, load extraction and
// the MEM/WB pipeline register feeding WriteBack.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears all W outputs
//   bus    memory_stage_if.slave: M-side inputs, StallW/FlushW, W outputs
// Optional build macro MEM_MISALIGN_TRAP_EN: adds MisalignW, suppresses
// misaligned stores and drops RegWriteW on misaligned accesses. Without it,
// misaligned offsets are truncated to the access width.
module memory_stage
    import rv_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    memory_stage_if.slave bus
);

    logic [1:0]        offset;
    logic [ADDR_W-1:0] wordAddr;
    logic [3:0]        laneEn;
    logic [3:0]        byteEn;
    logic [31:0]       laneData;
    logic [31:0]       readWord;
    logic [31:0]       loadData;
    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic              storeOk;
    logic              regWriteNext;

    assign offset   = bus.ALUResultM[1:0];
    assign wordAddr = bus.ALUResultM[ADDR_W+1:2];

    // A stalled instruction is re-presented next cycle, so its store must
    // wait; rst_n gating keeps a store from landing on an edge taken in reset.
`ifdef MEM_MISALIGN_TRAP_EN
    logic accessMisaligned;
    assign accessMisaligned = isMisaligned(bus.Funct3M, offset)
                              && (bus.MemWriteM || bus.ResultSrcM == RES_MEM);
    assign storeOk      = bus.MemWriteM && !bus.StallW && rst_n && !accessMisaligned;
    assign regWriteNext = bus.RegWriteM && !accessMisaligned;
`else
    assign storeOk      = bus.MemWriteM && !bus.StallW && rst_n;
    assign regWriteNext = bus.RegWriteM;
`endif

    // Replicating the store data across lanes lets the byte enables alone
    // pick the destination; offset[0] (and offset[1] for words) is ignored.
    always_comb begin
        laneEn   = 4'b0000;
        laneData = bus.WriteDataM;
        case (bus.Funct3M)
            F3_B: begin
                laneEn   = 4'b0001 << offset;
                laneData = {4{bus.WriteDataM[7:0]}};
            end
            F3_H: begin
                laneEn   = offset[1] ? 4'b1100 : 4'b0011;
                laneData = {2{bus.WriteDataM[15:0]}};
            end
            F3_W:    laneEn = 4'b1111;
            default: laneEn = 4'b0000;
        endcase
        byteEn = storeOk ? laneEn : 4'b0000;
    end

    data_memory #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dataMem (
        .clk      (clk),
        .wordAddr (wordAddr),
        .byteEn   (byteEn),
        .writeData(laneData),
        .readData (readWord)
    );

    always_comb begin
        loadByte = readWord[{offset, 3'b000} +: 8];
        loadHalf = offset[1] ? readWord[31:16] : readWord[15:0];
        case (bus.Funct3M)
            F3_B:    loadData = {{24{loadByte[7]}}, loadByte};
            F3_H:    loadData = {{16{loadHalf[15]}}, loadHalf};
            F3_W:    loadData = readWord;
            F3_BU:   loadData = {24'd0, loadByte};
            F3_HU:   loadData = {16'd0, loadHalf};
            default: loadData = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ALUResultW <= '0;
            bus.ReadDataW  <= '0;
            bus.ImmExtW    <= '0;
            bus.PCPlus4W   <= '0;
            bus.RdW        <= '0;
            bus.ResultSrcW <= '0;
            bus.RegWriteW  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            bus.MisalignW  <= 1'b0;
`endif
        end else if (!bus.StallW) begin
            if (bus.FlushW) begin
                bus.ALUResultW <= '0;
                bus.ReadDataW  <= '0;
                bus.ImmExtW    <= '0;
                bus.PCPlus4W   <= '0;
                bus.RdW        <= '0;
                bus.ResultSrcW <= '0;
                bus.RegWriteW  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                bus.MisalignW  <= 1'b0;
`endif
            end else begin
                bus.ALUResultW <= bus.ALUResultM;
                bus.ReadDataW  <= loadData;
                bus.ImmExtW    <= bus.ImmExtM;
                bus.PCPlus4W   <= bus.PCPlus4M;
                bus.RdW        <= bus.RdM;
                bus.ResultSrcW <= bus.ResultSrcM;
                bus.RegWriteW  <= regWriteNext;
`ifdef MEM_MISALIGN_TRAP_EN
                bus.MisalignW  <= accessMisaligned;
`endif
            end
        end
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly upstream of the WriteBack stage.
- Contains the byte-addressable data memory, store byte-lane generation, and load extraction with sign/zero extension.
- Contains the MEM/WB pipeline register, whose outputs drive WriteBack directly (ALUResultW, ReadDataW, ImmExtW, PCPlus4W, RdW, ResultSrcW).

Parameters:
- DEPTH, 256, number of 32-bit words in data memory; power of two.
- ADDR_W, 8, word-index width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ALUResultM  in  32  effective byte address / ALU result from EX/MEM.
- WriteDataM  in  32  store data (rs2).
- ImmExtM  in  32  extended immediate (LUI path).
- PCPlus4M  in  10  PC+4.
- RdM  in  5  destination register.
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 imm.
- Funct3M  in  3  load/store width code.
- MemWriteM  in  1  store enable.
- RegWriteM  in  1  register write enable.
- StallW  in  1  hold MEM/WB register.
- FlushW  in  1  insert bubble into MEM/WB register.
- ALUResultW, ReadDataW, ImmExtW  out  32 each  registered copies / load result.
- PCPlus4W  out  10  registered PC+4.
- RdW  out  5  registered destination.
- ResultSrcW  out  2  registered select.
- RegWriteW  out  1  registered write enable.

Behaviour:
- Reset (rst_n=0, asynchronous): all W outputs = 0.
  - Memory array is not cleared; its contents are undefined after power-up.
- Latency: 1 cycle. Values presented in cycle N appear on the W outputs after edge N+1.
- Addressing:
  - word index = ALUResultM[ADDR_W+1:2]; upper bits are ignored, so the address wraps modulo DEPTH*4.
  - byte offset = ALUResultM[1:0]; little-endian.
- Stores, when MemWriteM=1 and not suppressed; memory updates at the edge:
  - SB (000): write the byte at the offset from WriteDataM[7:0].
  - SH (001): write the halfword at offset[1] from WriteDataM[15:0].
  - SW (010): write the full word.
  - Other Funct3M: no write.
- Loads: the word is read combinationally from the array, then extracted per Funct3M and captured into ReadDataW at the edge.
  - LB 000 sign-extend byte; LH 001 sign-extend halfword; LW 010 word; LBU 100 zero-extend byte; LHU 101 zero-extend halfword.
  - Other codes give 0.
  - ReadDataW captures the extraction regardless of ResultSrcM.
- Read-after-write: a store at edge N is visible to a load presented in cycle N+1. The same instruction never both loads and stores.
- StallW=1:
  - All W registers hold their values.
  - Store is suppressed, because the instruction is re-presented and must commit exactly once.
- FlushW=1 (StallW=0):
  - W registers load a bubble: all fields 0, RegWriteW=0.
  - Store from M still commits.
- StallW and FlushW both 1: stall wins; hold, no store.
- Misaligned access (LH/LHU/SH with offset[0]=1; LW/SW with offset≠0), default build:
  - offset bits are truncated, i.e. halfword forced to an even offset and word to offset 0.
- Reset asserted mid-operation: W outputs clear immediately; a store on the same edge is suppressed while rst_n=0.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output MisalignW (1 bit, reset 0), registered with the other W fields.
  - A misaligned store is suppressed.
  - A misaligned load or store forces RegWriteW=0 and sets MisalignW=1 for that instruction.
  - Stall/flush/reset apply to MisalignW like the other W fields.
- Undefined: port absent; truncation behaviour as above.

Decomposition:
- Shared package (rv_pkg), localparams:
  - funct3 codes: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - ResultSrc encodings: RES_ALU, RES_MEM, RES_PC4, RES_IMM.
- One sub-module, data_memory:
  - DEPTH-word RAM with 4-bit byte-enable write and combinational read.
  - memory_stage owns lane/byte-enable generation, extraction and the MEM/WB register.

Test Plan:
- Reset: rst_n=0 mid-run → all W outputs 0 immediately; a store attempted that cycle leaves the word unchanged.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → ReadDataW=0xDEADBEEF one cycle after the load.
- Loads from 0x10:
  - LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x55 over 0xDEADBEEF, then LW 0x10 → 0xDEAD55EF.
- Address 0x400 (DEPTH=256) aliases 0x000.
- StallW=1 with SW 0x20 data 1 held 3 cycles, then StallW=0 → W outputs frozen during stall, single write observed. FlushW=1 → RegWriteW=0, RdW=0 next cycle.
- Misaligned LW 0x22:
  - Default build: truncation returns word at 0x20.
  - With MEM_MISALIGN_TRAP_EN: MisalignW=1, RegWriteW=0, and a misaligned SH leaves memory unchanged.
